// File: rtl/scratch_pad_reader_pkg.sv
// ============================================================================
//  Module      : scratch_pad_reader_pkg
//  Description : Shared definitions for the scratch pad reader: FSM state
//                encodings and the bit-width helper used to size pointers
//                and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scratch_pad_reader_pkg;

    // Reader FSM states (2-bit encoding)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Number of bits needed to hold the unsigned value 'value' (minimum 1).
    // log2(DEPTH-1) therefore gives the pointer width of a DEPTH-entry buffer.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo.sv
// ============================================================================
//  Module      : stream_fifo
//  Description : Synchronous FIFO with a registered head word. A write into
//                an empty FIFO lands directly in the head register, so data
//                written at edge R is visible on q in the following cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk    in   clock, rising edge
//    rst    in   asynchronous active-high reset (flushes the FIFO)
//    wr_en  in   push d
//    d      in   write data
//    rd_en  in   pop the head word (only meaningful while !empty)
//    q      out  head word (registered)
//    count  out  words held, including the head word
//    empty  out  no head word available
// ============================================================================
`default_nettype none

module stream_fifo
    import scratch_pad_reader_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          d,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          q,
    output logic [log2(DEPTH-1):0]    count,
    output logic                      empty
);

    localparam int PTR_W = log2(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   mem_cnt_q;
    logic             head_vld_q;
    logic [WIDTH-1:0] head_q;

    logic head_free;
    logic load_mem;
    logic load_d;
    logic mem_wr;

    // The head register refills from the array first; only when the array is
    // empty may the incoming word go straight into the head.
    assign head_free = !head_vld_q || rd_en;
    assign load_mem  = head_free && (mem_cnt_q != '0);
    assign load_d    = head_free && (mem_cnt_q == '0) && wr_en;
    assign mem_wr    = wr_en && !load_d;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (load_mem) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({mem_wr, load_mem})
                2'b10:   mem_cnt_q <= mem_cnt_q + (PTR_W+1)'(1);
                2'b01:   mem_cnt_q <= mem_cnt_q - (PTR_W+1)'(1);
                default: mem_cnt_q <= mem_cnt_q;
            endcase
            if (load_mem) begin
                head_q     <= mem_q[rd_ptr_q];
                head_vld_q <= 1'b1;
            end else if (load_d) begin
                head_q     <= d;
                head_vld_q <= 1'b1;
            end else if (head_free) begin
                head_vld_q <= 1'b0;
            end
        end
    end

    assign q     = head_q;
    assign empty = !head_vld_q;
    assign count = mem_cnt_q + {{PTR_W{1'b0}}, head_vld_q};

endmodule

`default_nettype wire

// File: rtl/scratch_pad_reader.sv
// ============================================================================
//  Module      : scratch_pad_reader
//  Description : Streams a contiguous scratch pad address range out on a
//                valid/ready interface. Requests are throttled by a credit
//                scheme so the response FIFO can never overflow, even if the
//                scratch pad ignores sp_stall.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst            clock / asynchronous active-high reset
//    start, base_addr,   job request (accepted in IDLE only)
//    count
//    busy, done, err     job status; err is sticky until rst
//    sp_rd_en, sp_addr   read request to the scratch pad port
//    sp_full             port cannot take a request this cycle
//    sp_q, sp_valid      in-order read responses
//    sp_stall            advisory response hold request
//    out_data,           output stream
//    out_valid,
//    out_ready
// ============================================================================
`default_nettype none

module scratch_pad_reader
    import scratch_pad_reader_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int COUNT_WIDTH = 16,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   sp_rd_en,
    output logic [ADDR_WIDTH-1:0]  sp_addr,
    input  logic                   sp_full,
    input  logic [WIDTH-1:0]       sp_q,
    input  logic                   sp_valid,
    output logic                   sp_stall,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CNT_W = log2(FIFO_DEPTH - 1) + 1;

    logic [1:0]             state_q,  state_d;
    logic [ADDR_WIDTH-1:0]  addr_q,   addr_d;
    logic [COUNT_WIDTH-1:0] remain_q, remain_d;
    logic [CNT_W-1:0]       outst_q,  outst_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic [CNT_W:0]         in_use;
    logic                   credit_ok;
    logic                   issue;
    logic                   resp_accept;
    logic                   pop;

    // Words that will occupy the FIFO once all outstanding responses land.
    assign in_use    = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok = in_use < (CNT_W+1)'(FIFO_DEPTH);

    assign issue       = (state_q == ST_ISSUE) && (remain_q != '0) && !sp_full && credit_ok;
    assign resp_accept = sp_valid && (outst_q != '0);
    assign pop         = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        // A response with nothing outstanding is dropped and flagged.
        err_d    = err_q | (sp_valid && (outst_q == '0));

        case ({issue, resp_accept})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = count;
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - COUNT_WIDTH'(1);
                    if (remain_q == COUNT_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Finish on the edge that pops the final word so done lands
                // in the cycle right after the last stream handshake.
                if ((outst_q == '0) &&
                    (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            outst_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            outst_q  <= outst_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (resp_accept),
        .d     (sp_q),
        .rd_en (pop),
        .q     (out_data),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign sp_rd_en  = issue;
    assign sp_addr   = addr_q;
    assign sp_stall  = fifo_count >= CNT_W'(FIFO_DEPTH - 2);
    assign out_valid = !fifo_empty;

endmodule

`default_nettype wire
